// File: rtl/dsp_mac_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer_pkg
//   Shared types and constants for the DSP MAC sequencer: FSM state encoding,
//   OPMODE words for the DSP slice, and the 2-bit tag that travels alongside
//   each operand pair through the slice's multiplier pipeline.
//   Optional feature macro used by the top: DSP_MAC_OVF_EN.
// -----------------------------------------------------------------------------
package dsp_mac_sequencer_pkg;

    localparam int OPND_W = 18;
    localparam int P_W    = 48;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // OPMODE words: bit 0 selects X=M, bit 3 selects Z=P.
    localparam logic [7:0] OPM_OFF   = 8'h00;
    localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P

    typedef struct packed {
        logic acc;    // a pair was accepted in the cycle this tag was pushed
        logic first;  // that pair was the first of the run
    } tag_t;

    function automatic logic [7:0] tag_opmode(input tag_t t);
        if (!t.acc)  return OPM_HOLD;
        if (t.first) return OPM_FIRST;
        return OPM_ACC;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// -----------------------------------------------------------------------------
// dsp_tag_pipe
//   DEPTH-deep shift register of tag_t, advancing only when en=1. Its output
//   lines up with the product of the pair that produced the tag reaching the
//   slice's post-adder.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low clear
//   en     in   shift enable
//   din    in   tag pushed this cycle
//   dout   out  tag at the end of the pipe
// -----------------------------------------------------------------------------
module dsp_tag_pipe
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  tag_t din,
    output tag_t dout
);

    tag_t [DEPTH-1:0] stage_q;

    // NOTE: the stages are reset, unlike a plain data delay line, because a
    // stale acc bit here would steer OPMODE on the first cycles of a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
//   Drives one DSP slice as a streaming multiply-accumulate engine: accepts
//   len (A,B) pairs, issues per-cycle OPMODE/CE/RST aligned to the slice's
//   MUL_LAT-deep multiplier pipeline, and returns sum(A*B) from P.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   start, len            one-cycle start pulse and pair count (sampled in IDLE)
//   busy                  high outside IDLE
//   in_valid/in_ready     operand stream handshake; in_a, in_b operands
//   dsp_a, dsp_b          operands to the slice (zero when nothing is accepted)
//   dsp_opmode            slice OPMODE (slice has no OPMODE register)
//   dsp_ce, dsp_rst       common clock enable / active-high reset for the slice
//   dsp_p                 slice P output
//   res_valid/res_ready   result handshake; res_data registered result
// Optional (macro DSP_MAC_OVF_EN):
//   dsp_carryout in, res_ovf out: sticky carry-out over accumulating cycles.
// -----------------------------------------------------------------------------
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    output logic [OPND_W-1:0] dsp_a,
    output logic [OPND_W-1:0] dsp_b,
    output logic [7:0]        dsp_opmode,
    output logic              dsp_ce,
    output logic              dsp_rst,
    input  logic [P_W-1:0]    dsp_p,
`ifdef DSP_MAC_OVF_EN
    input  logic              dsp_carryout,
    output logic              res_ovf,
`endif
    output logic              res_valid,
    input  logic              res_ready,
    output logic [P_W-1:0]    res_data
);

    // DRAIN lasts until the last product has been added into P.
    localparam int DRAIN_CYC = MUL_LAT + 1;
    localparam int CNT_W     = $clog2(DRAIN_CYC);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q;
    logic              first_q;
    logic [CNT_W-1:0]  drain_cnt_q;
    logic [P_W-1:0]    res_data_q;
    logic              accept, last_accept, drain_done;
    tag_t              tag_in, tag_out;

    assign in_ready    = (state_q == ST_STREAM) && (remaining_q != '0);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (remaining_q == LEN_W'(1));
    assign drain_done  = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST);

    assign busy      = (state_q != ST_IDLE);
    assign dsp_ce    = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign dsp_rst   = (state_q == ST_IDLE);
    assign dsp_a     = accept ? in_a : '0;
    assign dsp_b     = accept ? in_b : '0;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_data_q;

    assign tag_in = '{acc: accept, first: accept && first_q};

    dsp_tag_pipe #(.DEPTH(MUL_LAT)) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dsp_ce),
        .din   (tag_in),
        .dout  (tag_out)
    );

    // NOTE: flops use <= so every register samples pre-edge values; the
    // combinational block below uses = because it models wires, not state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d and dsp_opmode get defaults first so every path assigns
    // them and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        dsp_opmode = OPM_OFF;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (len == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                dsp_opmode = tag_opmode(tag_out);
                if (last_accept) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                dsp_opmode = tag_opmode(tag_out);
                if (drain_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pair counter, first-pair flag, drain timer and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            first_q     <= 1'b0;
            drain_cnt_q <= '0;
            res_data_q  <= '0;
        end else begin
            drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + CNT_W'(1) : '0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        remaining_q <= len;
                        first_q     <= 1'b1;
                        if (len == '0) res_data_q <= '0;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        first_q     <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // P now holds the complete sum; CE drops next cycle.
                    if (drain_done) res_data_q <= dsp_p;
                end
                default: ;
            endcase
        end
    end

`ifdef DSP_MAC_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && start) begin
            ovf_q <= 1'b0;
        end else if (dsp_ce && tag_out.acc && dsp_carryout) begin
            ovf_q <= 1'b1;
        end
    end

    assign res_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_sequencer
//   Bench for dsp_mac_sequencer together with a behavioural DSP slice
//   (A0/A1, B0/B1, M and P registers, combinational OPMODE). A transaction-
//   level reference tracks what the sequencer owes each cycle (ready, result
//   deadline, expected sum) and a per-cycle monitor compares against it.
// -----------------------------------------------------------------------------
module tb_dsp_mac_sequencer;

    localparam int LEN_W   = 10;
    localparam int MUL_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [17:0]       in_a = '0, in_b = '0;
    logic [17:0]       dsp_a, dsp_b;
    logic [7:0]        dsp_opmode;
    logic              dsp_ce, dsp_rst;
    logic [47:0]       dsp_p;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [47:0]       res_data;
`ifdef DSP_MAC_OVF_EN
    logic              dsp_carryout;
    logic              res_ovf;
`endif

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_opmode   (dsp_opmode),
        .dsp_ce       (dsp_ce),
        .dsp_rst      (dsp_rst),
        .dsp_p        (dsp_p),
`ifdef DSP_MAC_OVF_EN
        .dsp_carryout (dsp_carryout),
        .res_ovf      (res_ovf),
`endif
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data)
    );

    // ---------------- behavioural DSP slice ----------------
    logic [17:0] a0, b0, a1, b1;
    logic [35:0] m;
    logic [47:0] p, x_mux, z_mux;
    logic [48:0] post_sum;

    always_comb begin
        x_mux    = dsp_opmode[0] ? {12'b0, m} : 48'b0;
        z_mux    = dsp_opmode[3] ? p : 48'b0;
        post_sum = {1'b0, x_mux} + {1'b0, z_mux};
    end

    always @(posedge clk) begin
        if (dsp_rst) begin
            a0 <= '0; b0 <= '0; a1 <= '0; b1 <= '0; m <= '0; p <= '0;
        end else if (dsp_ce) begin
            a0 <= dsp_a;
            b0 <= dsp_b;
            a1 <= a0;
            b1 <= b0;
            m  <= {18'b0, a1} * {18'b0, b1};
            p  <= post_sum[47:0];
        end
    end

    assign dsp_p = p;
`ifdef DSP_MAC_OVF_EN
    assign dsp_carryout = post_sum[48];
`endif

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: owed pairs, result deadline and sum.
    bit          m_busy = 1'b0;
    int          m_rem  = 0;
    int          m_due  = -1;
    int          cyc    = 0;
    logic [47:0] m_sum  = '0;

    always @(negedge clk) begin
        bit exp_rdy, exp_rv, acc;
        if (!rst_n) begin
            check("rst_busy",      {63'b0, busy},      64'd0);
            check("rst_in_ready",  {63'b0, in_ready},  64'd0);
            check("rst_ce",        {63'b0, dsp_ce},    64'd0);
            check("rst_dsp_rst",   {63'b0, dsp_rst},   64'd1);
            check("rst_opmode",    {56'b0, dsp_opmode}, 64'h00);
            check("rst_res_valid", {63'b0, res_valid}, 64'd0);
            check("rst_res_data",  {16'b0, res_data},  64'd0);
            m_busy = 1'b0; m_rem = 0; m_due = -1;
        end else begin
            exp_rdy = m_busy && (m_rem > 0);
            exp_rv  = m_busy && (m_due >= 0) && (cyc >= m_due);
            acc     = in_valid && exp_rdy;
            check("busy",      {63'b0, busy},      {63'b0, m_busy});
            check("in_ready",  {63'b0, in_ready},  {63'b0, exp_rdy});
            check("res_valid", {63'b0, res_valid}, {63'b0, exp_rv});
            check("dsp_ce",    {63'b0, dsp_ce},    {63'b0, m_busy && !exp_rv});
            check("dsp_rst",   {63'b0, dsp_rst},   {63'b0, !m_busy});
            check("dsp_a",     {46'b0, dsp_a},     acc ? {46'b0, in_a} : 64'd0);
            check("dsp_b",     {46'b0, dsp_b},     acc ? {46'b0, in_b} : 64'd0);
            if (exp_rv) check("res_data", {16'b0, res_data}, {16'b0, m_sum});

            if (!m_busy && start) begin
                m_busy = 1'b1;
                m_sum  = '0;
                m_rem  = int'(len);
                m_due  = (len == '0) ? cyc + 1 : -1;
            end else if (acc) begin
                m_sum = m_sum + ({30'b0, in_a} * {30'b0, in_b});
                m_rem--;
                if (m_rem == 0) m_due = cyc + MUL_LAT + 2;
            end else if (exp_rv && res_ready) begin
                m_busy = 1'b0;
                m_due  = -1;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    logic [17:0] q_a[$];
    logic [17:0] q_b[$];
    logic        got_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction using the pairs in q_a/q_b; returns the result
    // read at the handshake.
    task automatic run_txn(input int n, input int gap, input int rdelay,
                           input bit poke_start, output logic [47:0] got);
        bit accepted, seen;
        tick();
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);   // must be ignored once latched
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) tick();
            in_valid = 1'b1;
            in_a     = q_a[i];
            in_b     = q_b[i];
            accepted = 1'b0;
            for (int k = 0; k < 20 && !accepted; k++) begin
                @(negedge clk);
                accepted = in_ready;
                tick();
            end
            if (!accepted) check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            in_a     = 18'($urandom);
            in_b     = 18'($urandom);
        end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = res_valid;
        end
        if (!seen) check("result_timeout", 64'd0, 64'd1);
        if (poke_start) begin
            tick();
            start = 1'b1;
            len   = LEN_W'(3);
            tick();
            start = 1'b0;
        end
        repeat (rdelay) tick();
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        got = res_data;
`ifdef DSP_MAC_OVF_EN
        got_ovf = res_ovf;
`else
        got_ovf = 1'b0;
`endif
        tick();
        res_ready = 1'b0;
    endtask

    task automatic load(input logic [17:0] a, input logic [17:0] b);
        q_a.push_back(a);
        q_b.push_back(b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [47:0] got, expv;
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Case 1: back-to-back pairs.
        q_a = {}; q_b = {};
        load(2, 3); load(4, 5); load(6, 7);
        run_txn(3, 0, 0, 1'b0, got);
        check("case1_sum", {16'b0, got}, 64'd68);
`ifdef DSP_MAC_OVF_EN
        check("case1_ovf", {63'b0, got_ovf}, 64'd0);
`endif

        // Case 2: two idle cycles between pairs.
        q_a = {}; q_b = {};
        load(1, 1); load(2, 2); load(3, 3); load(4, 4);
        run_txn(4, 2, 0, 1'b0, got);
        check("case2_sum", {16'b0, got}, 64'd30);

        // Case 3: empty run.
        q_a = {}; q_b = {};
        run_txn(0, 0, 0, 1'b0, got);
        check("case3_sum", {16'b0, got}, 64'd0);

        // Case 4: consumer stalls, stray start while the result is pending.
        q_a = {}; q_b = {};
        load(10, 10); load(5, 5);
        run_txn(2, 0, 6, 1'b1, got);
        check("case4_sum", {16'b0, got}, 64'd125);

        // Case 5: reset in the middle of a run, then a clean run.
        tick();
        start = 1'b1; len = LEN_W'(5);
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 18'd9; in_b = 18'd9;
        repeat (3) tick();
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        q_a = {}; q_b = {};
        load(7, 8);
        run_txn(1, 0, 0, 1'b0, got);
        check("case5_sum", {16'b0, got}, 64'd56);

        // Largest operands over a longer run.
        q_a = {}; q_b = {};
        expv = '0;
        for (int i = 0; i < 64; i++) begin
            load(18'h3FFFF, 18'h3FFFF);
            expv = expv + 48'h0000_000F_FFF8_0001;
        end
        run_txn(64, 0, 1, 1'b0, got);
        check("max_operands_sum", {16'b0, got}, {16'b0, expv});

        // Randomised runs.
        for (int t = 0; t < 25; t++) begin
            q_a = {}; q_b = {};
            expv = '0;
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) begin
                load(18'($urandom), 18'($urandom));
                expv = expv + ({30'b0, q_a[i]} * {30'b0, q_b[i]});
            end
            run_txn(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, got);
            check("random_sum", {16'b0, got}, {16'b0, expv});
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
